// File: rtl/proc_ctrl_pkg.sv
// Shared state encoding, opcode constants and decode helper for the stage sequencer.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6,
        StFault     = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Opcodes that proceed to EXECUTE; SYSTEM is handled separately.
    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles without ready and flags the cycle that exhausts the budget.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int unsigned W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Expires on the request cycle that would bring the count to MEM_TIMEOUT;
    // a ready in that same cycle takes priority.
    assign expired = (MEM_TIMEOUT != 0) && req && !ready && (cnt_q == LIMIT);

    // Wait counter: cleared on stage entry, advances on stalled request cycles.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (req && !ready && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/proc_stage_sequencer.sv
// Multi-cycle stage sequencer: one datapath stage per state, memory handshakes,
// halt/fault handling and performance counters.
module proc_stage_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             ex_en,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t state_q, state_d;
    logic   expired;
    logic   wait_clr;
    logic   wait_ready;

    assign state  = state_q;
    assign busy   = (state_q != StIdle) && (state_q != StHalt) && (state_q != StFault);
    assign halted = (state_q == StHalt);
    assign fault  = (state_q == StFault);

    // Clear the wait counter whenever a waiting stage is freshly entered.
    assign wait_clr   = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMemory));
    assign wait_ready = (state_q == StMemory) ? dmem_ready : imem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .req    (imem_req | dmem_req),
        .ready  (wait_ready),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stage strobes from the registered state plus ready inputs.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        ex_en    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                if (opcode == OP_SYSTEM)    state_d = StHalt;
                else if (is_exec_op(opcode)) state_d = StExecute;
                else                         state_d = StFault;
            end
            StExecute: begin
                ex_en = 1'b1;
                if (mem_read || mem_write) begin
                    state_d = StMemory;
                end else if (opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMemory: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    if (mem_write) begin
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (expired) begin
                    state_d = StFault;
                end
            end
            StWriteback: begin
                rf_we   = reg_write;
                pc_we   = 1'b1;
                state_d = StFetch;
            end
            StHalt, StFault: begin
                state_d = state_q;
            end
        endcase
    end

    // Performance counters: active cycles and retired instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (busy)  cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_we) instret   <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_proc_stage_sequencer.sv
// Directed bench for proc_stage_sequencer with a per-instruction scoreboard.
module tb_proc_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, mem_read, mem_write, reg_write, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, dmem_we, ir_we, ex_en, rf_we, pc_we;
    logic        busy, halted, fault;
    logic [2:0]  state;
    logic [63:0] cycle_cnt, instret;

    int n_cmp = 0;
    int n_err = 0;
    longint m_cycles = 0;
    longint m_instret = 0;

    typedef struct {
        string tag;
        int    cyc;
        int    ireq;
        int    dreq;
        int    irwe;
        int    ex;
        int    pc;
        bit    we;
        bit    rf;
        int    end_state;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    proc_stage_sequencer #(
        .MEM_TIMEOUT(15),
        .CNT_W      (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .ir_we     (ir_we),
        .ex_en     (ex_en),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_cycles  = 0;
        m_instret = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_to_imem_req", imem_req, 1'b1);
    endtask

    // Drives one instruction from FETCH until it retires, halts or faults.
    task automatic issue(input string tag, input logic [6:0] op, input logic mr, input logic mw,
                         input logic rw, input int iw, input int dw);
        exp_t e, g;
        bit   legal, tmo, memp, brn, done, last, hung;
        int   iwc, dwc;
        legal = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        tmo   = (iw >= 15);
        memp  = legal && (mr || mw);
        brn   = legal && !memp && (op == 7'b1100011);
        e.tag  = tag;
        e.ireq = tmo ? 15 : iw + 1;
        if (tmo)        e.cyc = 15;
        else if (!legal) e.cyc = e.ireq + 1;
        else if (memp)  e.cyc = e.ireq + 2 + dw + 1 + (mw ? 0 : 1);
        else if (brn)   e.cyc = e.ireq + 2;
        else            e.cyc = e.ireq + 3;
        e.dreq = (memp && !tmo) ? dw + 1 : 0;
        e.irwe = tmo ? 0 : 1;
        e.ex   = (legal && !tmo) ? 1 : 0;
        e.pc   = (legal && !tmo) ? 1 : 0;
        e.we   = memp && mw && !tmo;
        e.rf   = legal && !tmo && rw && !brn && !(memp && mw);
        e.end_state = tmo ? 7 : (legal ? 1 : ((op == 7'b1110011) ? 6 : 7));
        sb.push_back(e);
        m_cycles  += e.cyc;
        m_instret += e.pc;

        opcode = op; mem_read = mr; mem_write = mw; reg_write = rw;
        g = '{tag: tag, cyc: 0, ireq: 0, dreq: 0, irwe: 0, ex: 0, pc: 0,
              we: 1'b0, rf: 1'b0, end_state: 0};
        iwc = 0; dwc = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            imem_ready = imem_req && (iwc >= iw);
            dmem_ready = dmem_req && (dwc >= dw);
            #1;
            if (!busy) begin
                done = 1'b1;
            end else begin
                g.cyc++;
                if (imem_req) begin g.ireq++; if (!imem_ready) iwc++; end
                if (dmem_req) begin g.dreq++; if (!dmem_ready) dwc++; end
                if (ir_we)   g.irwe++;
                if (ex_en)   g.ex++;
                if (pc_we)   g.pc++;
                if (dmem_we) g.we = 1'b1;
                if (rf_we)   g.rf = 1'b1;
                last = pc_we;
                step();
                if (last) done = 1'b1;
            end
        end
        hung = !done;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        e = sb.pop_front();
        check({e.tag, "_finished"},  hung, 1'b0);
        check({e.tag, "_cycles"},    g.cyc, e.cyc);
        check({e.tag, "_imem_req"},  g.ireq, e.ireq);
        check({e.tag, "_dmem_req"},  g.dreq, e.dreq);
        check({e.tag, "_ir_we"},     g.irwe, e.irwe);
        check({e.tag, "_ex_en"},     g.ex, e.ex);
        check({e.tag, "_pc_we"},     g.pc, e.pc);
        check({e.tag, "_dmem_we"},   g.we, e.we);
        check({e.tag, "_rf_we"},     g.rf, e.rf);
        check({e.tag, "_state"},     state, e.end_state);
        check({e.tag, "_instret"},   instret, m_instret);
        check({e.tag, "_cycle_cnt"}, cycle_cnt, m_cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        do_reset();

        // Reset state.
        check("reset_state", state, 3'd0);
        check("reset_strobes",
              {imem_req, dmem_req, dmem_we, ir_we, ex_en, rf_we, pc_we, busy, halted, fault},
              10'd0);
        check("reset_cycle_cnt", cycle_cnt, 64'd0);
        check("reset_instret", instret, 64'd0);

        // rst wins over start.
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", state, 3'd0);

        // ALU, load with data waits, branch, store with fetch waits, fetch boundary.
        do_start();
        issue("rtype",   7'b0110011, 1'b0, 1'b0, 1'b1, 0, 0);
        issue("load_w3", 7'b0000011, 1'b1, 1'b0, 1'b1, 0, 3);
        issue("branch",  7'b1100011, 1'b0, 1'b0, 1'b1, 0, 0);
        issue("store",   7'b0100011, 1'b0, 1'b1, 1'b0, 2, 0);
        issue("imm_edge", 7'b0010011, 1'b0, 1'b0, 1'b1, 14, 0);

        // Reset in the middle of a data wait abandons the access.
        opcode = 7'b0000011; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        check("mid_mem_state", state, 3'd4);
        check("mid_mem_req", {dmem_req, dmem_we}, 2'b10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mem_state", state, 3'd0);
        check("rst_mem_dmem_req", dmem_req, 1'b0);
        check("rst_mem_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_mem_instret", instret, 64'd0);
        dmem_ready = 1'b1;
        #1;
        check("stray_ready_req", dmem_req, 1'b0);
        step();
        dmem_ready = 1'b0;
        check("stray_ready_state", state, 3'd0);
        check("stray_ready_instret", instret, 64'd0);
        m_cycles = 0; m_instret = 0;

        // Illegal opcode.
        do_start();
        issue("illegal", 7'b1111111, 1'b0, 1'b0, 1'b0, 0, 0);
        check("illegal_fault", fault, 1'b1);

        // SYSTEM halts without retiring; start is ignored afterwards.
        do_reset();
        do_start();
        issue("system", 7'b1110011, 1'b0, 1'b0, 1'b0, 0, 0);
        check("system_halted", halted, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("halt_absorbs_start", state, 3'd6);

        // Fetch timeout.
        do_reset();
        do_start();
        issue("fetch_timeout", 7'b0110011, 1'b0, 1'b0, 1'b1, 1000, 0);
        check("timeout_fault", fault, 1'b1);
        check("timeout_imem_req", imem_req, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("fault_absorbs_start", state, 3'd7);
        check("fault_no_req", imem_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proc_stage_sequencer.md
# proc_stage_sequencer

Multi-cycle control FSM that sequences the RV64 datapath (fetch, decode, execute, memory access, write-back) one stage per state. It stalls each stage on ready/valid handshakes with instruction and data memory. It issues per-stage enables, stops on SYSTEM opcodes, faults on illegal opcodes or memory timeouts, and keeps cycle and retired-instruction counters. It sits beside the processor top, and its enables gate the PC, instruction, ALU-result and register-file write paths.

## Interface
- MEM_TIMEOUT, 15: maximum request cycles allowed without ready; 0 disables the timeout.
- CNT_W, 64: width of the performance counters.

- clk  in  1  clock; everything is synchronous to the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins execution, honoured only in IDLE.
- opcode  in  7  instruction[6:0] of the latched instruction.
- mem_read  in  1  decoded load flag.
- mem_write  in  1  decoded store flag.
- reg_write  in  1  decoded register-write flag.
- imem_ready  in  1  instruction memory completes the current request.
- dmem_ready  in  1  data memory completes the current request.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a write.
- ir_we  out  1  latch the instruction register.
- ex_en  out  1  latch the ALU result and zero flag.
- rf_we  out  1  register file write enable.
- pc_we  out  1  update the PC; also marks instruction retire.
- busy  out  1  FSM is in a stage state.
- halted  out  1  sticky stop after a SYSTEM opcode.
- fault  out  1  sticky error.
- state  out  3  current state, for debug.
- cycle_cnt  out  CNT_W  active cycle count.
- instret  out  CNT_W  retired instruction count.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- **IDLE:** start=1 moves to FETCH.
- **FETCH:** imem_req=1.
  - imem_ready=1: ir_we pulses in that same cycle, then DECODE.
- **DECODE:** classifies the opcode.
  - 1110011 (SYSTEM) goes to HALT.
  - Legal opcodes go to EXECUTE: 0110011, 0010011, 0000011, 0100011, 1100011.
  - Any other opcode goes to FAULT.
- **EXECUTE:** ex_en=1 for one cycle.
  - mem_read or mem_write set: go to MEMORY.
  - Opcode 1100011 (branch): pc_we=1 and go to FETCH.
  - Otherwise: go to WRITEBACK.
- **MEMORY:** dmem_req=1 and dmem_we=mem_write, both held until ready.
  - dmem_ready with a store: pc_we=1, then FETCH.
  - dmem_ready with a load: go to WRITEBACK.
- **WRITEBACK:** rf_we=reg_write and pc_we=1, then FETCH.
- **HALT and FAULT:** absorbing until rst. start is ignored. All strobes are 0.
- **Timeout:**
  - A wait counter clears on entry to FETCH or MEMORY and increments on each request cycle with ready=0.
  - When it reaches MEM_TIMEOUT with ready still low, the next state is FAULT.
  - ready arriving in the same cycle as the limit wins, and the access completes.
- **Counters:**
  - cycle_cnt increments in states 1 to 5.
  - instret increments on each pc_we pulse.
  - Both wrap modulo 2^CNT_W.
  - The halting instruction does not retire.
- **Other rules:**
  - imem_ready or dmem_ready without a matching request is ignored.
  - rst together with start: rst wins.

## Timing
- **Reset values:** all outputs 0, state=IDLE, counters 0, wait counter 0.
- **Outputs:** all strobes are Moore/Mealy combinational from the registered state plus the ready inputs. No output register is added.
- **Latency with ready asserted on the first request cycle:**
  - ALU op: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each extra wait cycle adds 1.
- **Start:** start sampled in IDLE puts imem_req high in the next cycle.
- **Reset mid-operation:** the edge with rst=1 returns to IDLE. Requests drop that cycle. Partial accesses are abandoned and must not retire.

## Structure
- The package proc_ctrl_pkg holds:
  - the state encoding constants;
  - the opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM.
- The timeout is a natural sub-module, mem_wait_timer:
  - parameter MEM_TIMEOUT;
  - ports: clr, req, ready, expired.

## Test plan
- **R-type, immediate ready:** start, opcode 0110011, reg_write=1.
  - Expect ir_we in cycle 1, ex_en in cycle 3, rf_we=pc_we=1 in cycle 4.
  - After cycle 4: instret=1, cycle_cnt=4.
- **Load, delayed data ready:** opcode 0000011, mem_read=1, dmem_ready after 3 wait cycles.
  - Expect dmem_req high for 4 cycles with dmem_we=0, then WRITEBACK.
  - Instruction takes 8 cycles in total.
- **Branch then store:** opcode 1100011, then opcode 0100011 with mem_write=1.
  - Branch retires in EXECUTE (3 cycles) and rf_we is never asserted.
  - Store retires in MEMORY with dmem_we=1.
  - Result: instret=2.
- **Fetch timeout:** MEM_TIMEOUT=15, imem_ready held 0.
  - Expect exactly 15 imem_req cycles, then FAULT with fault=1 and imem_req=0.
  - start is ignored afterwards.
- **Illegal opcode and halt:**
  - Opcode 1111111 → fault=1.
  - After rst, opcode 1110011 → halted=1, instret unchanged, no pc_we.
- **Reset mid-MEMORY:** rst asserted during a dmem wait.
  - Next cycle: state=0, dmem_req=0, counters 0.
  - A dmem_ready arriving then is ignored.
